rival_traffic_ctrl: RTL and testbench



---
 rtl/rival_traffic_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rival_traffic_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rival_traffic_ctrl.sv
// Rival car spawn/move/retire with player overlap detection and an 8-bit LFSR.
// Optional feature macro RIVAL_SPEEDUP_EN: per-rival step grows with pass_cnt, latched at spawn.
module rival_traffic_ctrl #(
  parameter int unsigned LANE_X0    = 50,
  parameter int unsigned LANE_PITCH = 40,
  parameter int unsigned CAR_W      = 14,
  parameter int unsigned CAR_H      = 16,
  parameter int unsigned SPAWN_Y    = 0,
  parameter int unsigned BOTTOM_Y   = 300,
  parameter int unsigned SPEED      = 1,
  parameter int unsigned SPAWN_GAP  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic [9:0] car_x,
  input  logic [9:0] car_y,
  output logic [9:0] rival_x,
  output logic [9:0] rival_y,
  output logic       rival_active,
  output logic [7:0] random_num,
  output logic       collision,
  output logic [7:0] pass_cnt
);

  localparam int unsigned PW  = 10;
  localparam int unsigned PWW = PW + 1;
  localparam int unsigned GW  = $clog2(SPAWN_GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MOVE, S_HIT} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  x_q, x_d;
  logic [PW-1:0]  y_q, y_d;
  logic           active_q, active_d;
  logic           coll_q, coll_d;
  logic [7:0]     lfsr_q, lfsr_d;
  logic [7:0]     pass_q, pass_d;
  logic [GW-1:0]  gap_q, gap_d;

  logic [PW-1:0]  step_c;
  logic [PW-1:0]  dx_c, dy_c;
  logic           overlap_c;
  logic [PWW-1:0] y_sum_c;
  logic [PW-1:0]  spawn_x_c;

`ifdef RIVAL_SPEEDUP_EN
  logic [PW-1:0]  step_q, step_d;
  logic [1:0]     bump_c;

  // +1 px/frame per 8 passes, capped at +3
  assign bump_c = (pass_q[7:3] > 5'd3) ? 2'd3 : pass_q[4:3];
  assign step_c = step_q;
`else
  assign step_c = PW'(SPEED);
`endif

  // Unsigned distance avoids wrap; identical to an 11-bit signed abs difference
  always_comb begin
    dx_c      = (car_x >= x_q) ? (car_x - x_q) : (x_q - car_x);
    dy_c      = (car_y >= y_q) ? (car_y - y_q) : (y_q - car_y);
    overlap_c = (dx_c < PW'(CAR_W)) && (dy_c < PW'(CAR_H));
    y_sum_c   = {1'b0, y_q} + {1'b0, step_c};
    spawn_x_c = PW'(LANE_X0) + PW'(lfsr_q[1:0]) * PW'(LANE_PITCH);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    coll_d   = 1'b0;
    pass_d   = pass_q;
    gap_d    = gap_q;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`ifdef RIVAL_SPEEDUP_EN
    step_d   = step_q;
`endif

    case (state_q)
      S_IDLE: begin
        active_d = 1'b0;
        if (run) begin
          state_d = S_WAIT;
          gap_d   = GW'(SPAWN_GAP);
          pass_d  = 8'd0;
        end
      end
      S_WAIT: begin
        if (!run) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
          x_d      = '0;
          y_d      = '0;
        end else if (frame_tick) begin
          if (gap_q <= GW'(1)) begin
            state_d  = S_MOVE;
            x_d      = spawn_x_c;
            y_d      = PW'(SPAWN_Y);
            active_d = 1'b1;
`ifdef RIVAL_SPEEDUP_EN
            step_d   = PW'(SPEED) + PW'(bump_c);
`endif
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
      end
      S_MOVE: begin
        // Collision outranks a coincident frame tick
        if (!run) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
          x_d      = '0;
          y_d      = '0;
        end else if (overlap_c) begin
          state_d = S_HIT;
          coll_d  = 1'b1;
        end else if (frame_tick) begin
          if (y_sum_c > PWW'(BOTTOM_Y)) begin
            state_d  = S_WAIT;
            active_d = 1'b0;
            gap_d    = GW'(SPAWN_GAP);
            pass_d   = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
          end else begin
            y_d = y_sum_c[PW-1:0];
          end
        end
      end
      S_HIT: begin
        if (!run) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
          x_d      = '0;
          y_d      = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      coll_q   <= 1'b0;
      lfsr_q   <= 8'hA5;
      pass_q   <= 8'd0;
      gap_q    <= '0;
`ifdef RIVAL_SPEEDUP_EN
      step_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      coll_q   <= coll_d;
      lfsr_q   <= lfsr_d;
      pass_q   <= pass_d;
      gap_q    <= gap_d;
`ifdef RIVAL_SPEEDUP_EN
      step_q   <= step_d;
`endif
    end
  end

  assign rival_x      = x_q;
  assign rival_y      = y_q;
  assign rival_active = active_q;
  assign random_num   = lfsr_q;
  assign collision    = coll_q;
  assign pass_cnt     = pass_q;

endmodule

// File: tb/tb_rival_traffic_ctrl.sv
// Self-checking bench for rival_traffic_ctrl: vector table, directed corner sequences,
// and randomized stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_rival_traffic_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       run;
  logic [9:0] car_x;
  logic [9:0] car_y;
  logic [9:0] rival_x;
  logic [9:0] rival_y;
  logic       rival_active;
  logic [7:0] random_num;
  logic       collision;
  logic [7:0] pass_cnt;

  int checks = 0;
  int errors = 0;

  rival_traffic_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .run          (run),
    .car_x        (car_x),
    .car_y        (car_y),
    .rival_x      (rival_x),
    .rival_y      (rival_y),
    .rival_active (rival_active),
    .random_num   (random_num),
    .collision    (collision),
    .pass_cnt     (pass_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Behavioural model: game session on/off, countdown to spawn, rival box, hit flag
  bit         m_on, m_active, m_hit, m_coll;
  int         m_wait, m_x, m_y, m_step, m_pass;
  logic [7:0] m_lfsr;

  task automatic model_reset();
    m_on = 0; m_active = 0; m_hit = 0; m_coll = 0;
    m_wait = 0; m_x = 0; m_y = 0; m_step = 0; m_pass = 0;
    m_lfsr = 8'hA5;
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int model_step();
`ifdef RIVAL_SPEEDUP_EN
    int b;
    b = m_pass / 8;
    return 1 + ((b > 3) ? 3 : b);
`else
    return 1;
`endif
  endfunction

  task automatic model_edge();
    bit c;
    int dx, dy;
    c  = 0;
    dx = iabs(int'(car_x) - m_x);
    dy = iabs(int'(car_y) - m_y);
    if (!m_on) begin
      if (run) begin m_on = 1; m_wait = 32; m_pass = 0; end
    end else if (!run) begin
      m_on = 0; m_active = 0; m_hit = 0; m_x = 0; m_y = 0;
    end else if (m_hit) begin
      c = 0;
    end else if (!m_active) begin
      if (frame_tick) begin
        if (m_wait == 1) begin
          m_active = 1;
          m_x = 50 + 40 * (int'(m_lfsr) % 4);
          m_y = 0;
          m_step = model_step();
        end else begin
          m_wait--;
        end
      end
    end else if (dx < 14 && dy < 16) begin
      m_hit = 1; c = 1;
    end else if (frame_tick) begin
      if (m_y + m_step > 300) begin
        m_active = 0; m_wait = 32;
        if (m_pass < 255) m_pass++;
      end else begin
        m_y += m_step;
      end
    end
    m_coll = c;
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    checks++;
    if (rival_x !== 10'(m_x) || rival_y !== 10'(m_y) || rival_active !== m_active ||
        random_num !== m_lfsr || collision !== m_coll || pass_cnt !== 8'(m_pass)) begin
      errors++;
      $display("FAIL model_%s t=%0t got x=%0d y=%0d a=%0b rn=%h c=%0b p=%0d want x=%0d y=%0d a=%0b rn=%h c=%0b p=%0d",
               tag, $time, rival_x, rival_y, rival_active, random_num, collision, pass_cnt,
               m_x, m_y, m_active, m_lfsr, m_coll, m_pass);
    end
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic park_car();
    car_x = 10'd1000;
    car_y = 10'd1000;
  endtask

  task automatic ticks(int n, string tag);
    frame_tick = 1'b1;
    for (int i = 0; i < n; i++) cycle(tag);
    frame_tick = 1'b0;
  endtask

  typedef struct {
    bit         run;
    bit         tick;
    logic [7:0] rn;
    bit         act;
    logic [7:0] pc;
  } vec_t;

  vec_t tbl[5];

`ifdef RIVAL_SPEEDUP_EN
  task automatic spawn_step_check(int min_pass, int exp_step);
    int  n;
    bit  ok;
    bit  was;
    int  y0;
    n = 0; ok = 0;
    frame_tick = 1'b1;
    while (n < 20000) begin
      was = rival_active;
      cycle("spd");
      n++;
      if (!was && rival_active && int'(pass_cnt) >= min_pass) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("spd_timeout", 0, 1);
    end else begin
      y0 = int'(rival_y);
      cycle("spd");
      chk("spd_step", int'(rival_y) - y0, exp_step);
    end
  endtask
`endif

  initial begin
    int v;
    // feedback b7^b5^b4^b3 from seed A5: A5 -> 4A -> 95 -> 2A -> 54 -> A9
    tbl[0] = '{run: 0, tick: 0, rn: 8'h4A, act: 0, pc: 8'd0};
    tbl[1] = '{run: 0, tick: 1, rn: 8'h95, act: 0, pc: 8'd0};
    tbl[2] = '{run: 0, tick: 0, rn: 8'h2A, act: 0, pc: 8'd0};
    tbl[3] = '{run: 1, tick: 0, rn: 8'h54, act: 0, pc: 8'd0};
    tbl[4] = '{run: 1, tick: 1, rn: 8'hA9, act: 0, pc: 8'd0};

    model_reset();
    rst_n = 1'b0; run = 1'b0; frame_tick = 1'b0;
    park_car();
    #12;
    chk("rst_x", int'(rival_x), 0);
    chk("rst_y", int'(rival_y), 0);
    chk("rst_active", int'(rival_active), 0);
    chk("rst_rn", int'(random_num), 8'hA5);
    chk("rst_coll", int'(collision), 0);
    chk("rst_pass", int'(pass_cnt), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run = tbl[i].run;
      frame_tick = tbl[i].tick;
      cycle("tbl");
      chk("tbl_rn", int'(random_num), int'(tbl[i].rn));
      chk("tbl_active", int'(rival_active), int'(tbl[i].act));
      chk("tbl_pass", int'(pass_cnt), int'(tbl[i].pc));
    end

    // Remaining 31 ticks of the first gap; the 32nd tick spawns
    frame_tick = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      cycle("spawn");
      if (i == 30) chk("pre_spawn_active", int'(rival_active), 0);
    end
    chk("spawn_active", int'(rival_active), 1);
    chk("spawn_y", int'(rival_y), 0);
    chk("spawn_lane", (rival_x == 10'd50 || rival_x == 10'd90 ||
                       rival_x == 10'd130 || rival_x == 10'd170) ? 1 : 0, 1);

    ticks(300, "travel");
    chk("bottom_y", int'(rival_y), 300);
    chk("bottom_active", int'(rival_active), 1);
    ticks(1, "retire");
    chk("retire_active", int'(rival_active), 0);
    chk("retire_pass", int'(pass_cnt), 1);

    // Corner overlap at (+13,+15), then freeze and stop
    ticks(32, "respawn");
    chk("respawn_active", int'(rival_active), 1);
    ticks(20, "adv");
    chk("adv_y", int'(rival_y), 20);
    car_x = 10'(m_x + 13); car_y = 10'(m_y + 15);
    cycle("hit");
    chk("hit_pulse", int'(collision), 1);
    frame_tick = 1'b1;
    cycle("hit_hold");
    chk("hit_single", int'(collision), 0);
    chk("hit_frozen", int'(rival_y), 20);
    cycle("hit_hold2");
    chk("hit_active", int'(rival_active), 1);
    run = 1'b0; frame_tick = 1'b0;
    cycle("stop");
    chk("stop_active", int'(rival_active), 0);

    // Edge-of-box misses, then a near-side hit
    park_car(); run = 1'b1;
    cycle("restart");
    ticks(32, "spawn2");
    car_x = 10'(m_x + 14); car_y = 10'(m_y);
    for (int i = 0; i < 3; i++) begin cycle("miss_x"); chk("miss_xp14", int'(collision), 0); end
    car_x = 10'(m_x - 14);
    for (int i = 0; i < 3; i++) begin cycle("miss_x"); chk("miss_xm14", int'(collision), 0); end
    car_x = 10'(m_x); car_y = 10'(m_y + 16);
    for (int i = 0; i < 3; i++) begin cycle("miss_y"); chk("miss_yp16", int'(collision), 0); end
    car_x = 10'(m_x - 13); car_y = 10'(m_y + 15);
    cycle("hit_left");
    chk("hit_left_pulse", int'(collision), 1);
    run = 1'b0;
    cycle("stop2");

    // Overlap on the same cycle as a frame tick
    park_car(); run = 1'b1;
    cycle("restart3");
    ticks(32, "spawn3");
    ticks(5, "adv3");
    car_x = 10'(m_x); car_y = 10'(m_y);
    frame_tick = 1'b1;
    cycle("tick_hit");
    chk("tick_hit_pulse", int'(collision), 1);
    chk("tick_hit_y", int'(rival_y), 5);
    cycle("tick_hit2");
    chk("tick_hit_y2", int'(rival_y), 5);
    run = 1'b0; frame_tick = 1'b0;
    cycle("stop3");

    // Randomized traffic against the model
    park_car();
    for (int i = 0; i < 5000; i++) begin
      run = ($urandom_range(99) != 0);
      frame_tick = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) begin
        v = m_x + int'($urandom_range(40)) - 20;
        car_x = 10'((v < 0) ? 0 : v);
        v = m_y + int'($urandom_range(40)) - 20;
        car_y = 10'((v < 0) ? 0 : v);
      end else if ($urandom_range(3) == 0) begin
        park_car();
      end
      cycle("rand");
    end

    // Asynchronous reset mid-operation
    run = 1'b1; park_car(); frame_tick = 1'b1;
    for (int i = 0; i < 40; i++) cycle("pre_arst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_active", int'(rival_active), 0);
    chk("arst_x", int'(rival_x), 0);
    chk("arst_rn", int'(random_num), 8'hA5);
    chk("arst_pass", int'(pass_cnt), 0);
    model_reset();
    run = 1'b0; frame_tick = 1'b0;
    #2;
    rst_n = 1'b1;
    cycle("post_arst");
    chk("post_arst_rn", int'(random_num), 8'h4A);

`ifdef RIVAL_SPEEDUP_EN
    run = 1'b1; park_car();
    cycle("spd_start");
    spawn_step_check(8, 2);
    spawn_step_check(24, 4);
    run = 1'b0; frame_tick = 1'b0;
    cycle("spd_stop");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
